// File: rtl/data_transposer.sv
// data_transposer: collects NUM_WORDS elements and writes them to MVU data RAM as bit planes.
// Define DATA_TRANSPOSER_LSB_FIRST_EN to write the LSB plane at baddr instead of the MSB plane.
module data_transposer #(
  parameter int NUM_WORDS     = 64,
  parameter int XLEN          = 32,
  parameter int MVU_ADDR_LEN  = 15,
  parameter int MVU_DATA_LEN  = 64,
  parameter int MAX_DATA_PREC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             prec,
  input  logic [31:0]             baddr,
  input  logic [XLEN-1:0]         iword,
  input  logic                    start,
  output logic                    busy,
  output logic                    mvu_wr_en,
  output logic [MVU_ADDR_LEN-1:0] mvu_wr_addr,
  output logic [MVU_DATA_LEN-1:0] mvu_wr_word
);
  localparam int CW = $clog2(NUM_WORDS + MAX_DATA_PREC + 1);
  localparam int PW = $clog2(MAX_DATA_PREC + 1);
  localparam int IW = (MAX_DATA_PREC > 1) ? $clog2(MAX_DATA_PREC) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] p, p_n, p_in, k, idx;
  logic [MVU_ADDR_LEN-1:0] base, base_n, addr_n;
  logic [MVU_DATA_LEN-1:0] word_n, src;
  logic busy_n, wr_en_n, shift_en;
  logic [MVU_DATA_LEN-1:0] planes [MAX_DATA_PREC];
  logic [MVU_DATA_LEN-1:0] shifted [MAX_DATA_PREC];
  // Each element shifts in from the top, so after NUM_WORDS shifts element i sits at bit i.
  for (genvar g = 0; g < MAX_DATA_PREC; g++) begin : g_plane
    assign shifted[g] = {iword[g], planes[g][MVU_DATA_LEN-1:1]};
  end
  assign shift_en = (state == LOAD) || (state == IDLE && start);
  assign p_in = (prec > 32'(MAX_DATA_PREC)) ? PW'(MAX_DATA_PREC) : prec[PW-1:0];
  assign k = (state == WRITE) ? cnt[PW-1:0] : '0;
`ifdef DATA_TRANSPOSER_LSB_FIRST_EN
  assign idx = k;
`else
  assign idx = p - PW'(1) - k;
`endif
  // The first plane is emitted on the edge that captures the last element, so read the shifted view.
  assign src = (state == LOAD) ? shifted[idx[IW-1:0]] : planes[idx[IW-1:0]];
  always_ff @(posedge clk)
    if (shift_en) planes <= shifted;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p_n     = p;
    base_n  = base;
    busy_n  = busy;
    wr_en_n = 1'b0;
    addr_n  = '0;
    word_n  = '0;
    case (state)
      IDLE: if (start) begin
        state_n = (prec == 32'd0) ? WRITE : LOAD;
        cnt_n   = CW'(1);
        p_n     = p_in;
        base_n  = baddr[MVU_ADDR_LEN-1:0];
        busy_n  = 1'b1;
      end
      LOAD: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(NUM_WORDS - 1)) begin
          state_n = WRITE;
          cnt_n   = CW'(1);
          wr_en_n = 1'b1;
          addr_n  = base;
          word_n  = src;
        end
      end
      WRITE: if (cnt < CW'(p)) begin
        cnt_n   = cnt + CW'(1);
        wr_en_n = 1'b1;
        addr_n  = base + MVU_ADDR_LEN'(cnt);
        word_n  = src;
      end else begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      base        <= '0;
      busy        <= 1'b0;
      mvu_wr_en   <= 1'b0;
      mvu_wr_addr <= '0;
      mvu_wr_word <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      p           <= p_n;
      base        <= base_n;
      busy        <= busy_n;
      mvu_wr_en   <= wr_en_n;
      mvu_wr_addr <= addr_n;
      mvu_wr_word <= word_n;
    end
endmodule

// File: tb/tb_data_transposer.sv
// tb_data_transposer: table-driven and randomized checks of data_transposer against a plane model.
module tb_data_transposer;
  localparam int NW = 64, AW = 15, DW = 64, MP = 16;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] prec = 0, baddr = 0, iword = 0;
  logic busy, mvu_wr_en;
  logic [AW-1:0] mvu_wr_addr;
  logic [DW-1:0] mvu_wr_word;
  logic [31:0] elems [NW];
  int total = 0, bad = 0;
  typedef struct {
    logic [31:0] prec;
    logic [31:0] baddr;
    int          pat;
    int          np;
    bit          cc;
    logic [63:0] first;
    logic [63:0] last;
  } vec_t;
  vec_t tbl [6];
  data_transposer dut (
    .clk(clk), .rst_n(rst_n), .prec(prec), .baddr(baddr), .iword(iword), .start(start),
    .busy(busy), .mvu_wr_en(mvu_wr_en), .mvu_wr_addr(mvu_wr_addr), .mvu_wr_word(mvu_wr_word)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  // Plane k of the batch: bit (p-1-k) of every element, or bit k in the LSB-first build.
  function automatic logic [63:0] plane(input int p, input int k);
    logic [63:0] w = '0;
    int b;
`ifdef DATA_TRANSPOSER_LSB_FIRST_EN
    b = k;
`else
    b = p - 1 - k;
`endif
    for (int i = 0; i < NW; i++) w[i] = elems[i][b];
    return w;
  endfunction
  task automatic fill(input int pat);
    for (int i = 0; i < NW; i++)
      elems[i] = (pat == 0) ? 32'(i % 4) : (pat == 1) ? 32'((i + 1) % 2) :
                 (pat == 2) ? 32'h000F_FFFF : $urandom;
  endtask
  task automatic run_batch(input logic [31:0] pr, input logic [31:0] ba, input int pulse,
                           output logic [63:0] first, output logic [63:0] last, output int nwr);
    int p, last_c, k;
    logic exp_en;
    p = (pr > 32'(MP)) ? MP : int'(pr);
    last_c = (p == 0) ? 2 : NW + p;
    first = '0; last = '0; nwr = 0;
    chk("idle_before_start", 64'(busy), 64'(0));
    start = 1; prec = pr; baddr = ba; iword = elems[0];
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk); #1;
      exp_en = (p > 0) && (c >= NW) && (c <= NW + p - 1);
      k = c - NW;
      chk("busy", 64'(busy), 64'((p == 0) ? (c == 1) : (c <= NW + p - 1)));
      chk("wr_en", 64'(mvu_wr_en), 64'(exp_en));
      chk("wr_addr", 64'(mvu_wr_addr), exp_en ? 64'(AW'(ba + 32'(k))) : 64'(0));
      chk("wr_word", mvu_wr_word, exp_en ? plane(p, k) : 64'(0));
      if (mvu_wr_en) begin
        if (nwr == 0) first = mvu_wr_word;
        last = mvu_wr_word;
        nwr++;
      end
      start = (c == pulse);
      prec  = $urandom;
      baddr = $urandom;
      iword = (c < NW) ? elems[c] : $urandom;
    end
  endtask
  initial begin
    logic [63:0] f, l;
    int n;
    tbl[0] = '{32'd2, 32'h100, 0, 2, 1'b1, 64'hCCCC_CCCC_CCCC_CCCC, 64'hAAAA_AAAA_AAAA_AAAA};
    tbl[1] = '{32'd1, 32'h2000, 1, 1, 1'b1, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555};
    tbl[2] = '{32'd20, 32'h40, 2, 16, 1'b1, {64{1'b1}}, {64{1'b1}}};
    tbl[3] = '{32'd0, 32'h77, 3, 0, 1'b1, 64'h0, 64'h0};
    tbl[4] = '{32'd5, 32'hABCD_7FFE, 3, 5, 1'b0, 64'h0, 64'h0};
    tbl[5] = '{32'hFFFF_FFFF, 32'h10, 3, 16, 1'b0, 64'h0, 64'h0};
`ifdef DATA_TRANSPOSER_LSB_FIRST_EN
    tbl[0].first = 64'hAAAA_AAAA_AAAA_AAAA;
    tbl[0].last  = 64'hCCCC_CCCC_CCCC_CCCC;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_wr_en", 64'(mvu_wr_en), 64'(0));
    chk("rst_wr_addr", 64'(mvu_wr_addr), 64'(0));
    chk("rst_wr_word", mvu_wr_word, 64'(0));
    rst_n = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("idle_ctrl", 64'({busy, mvu_wr_en}), 64'(0));
      chk("idle_data", mvu_wr_word | 64'(mvu_wr_addr), 64'(0));
    end
    for (int t = 0; t < 6; t++) begin
      fill(tbl[t].pat);
      run_batch(tbl[t].prec, tbl[t].baddr, -1, f, l, n);
      chk("tbl_nwr", 64'(n), 64'(tbl[t].np));
      if (tbl[t].cc) begin
        chk("tbl_first", f, tbl[t].first);
        chk("tbl_last", l, tbl[t].last);
      end
    end
    fill(3);
    run_batch(32'd3, 32'h300, 10, f, l, n);
    chk("pulse_nwr", 64'(n), 64'(3));
    for (int r = 0; r < 6; r++) begin
      fill(3);
      run_batch(32'($urandom_range(0, 20)), $urandom, int'($urandom_range(1, 40)), f, l, n);
    end
    fill(3);
    start = 1; prec = 32'd8; baddr = 32'h500; iword = elems[0];
    for (int c = 1; c < 30; c++) begin
      @(posedge clk); #1;
      start = 0; iword = elems[c];
    end
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_wr_en", 64'(mvu_wr_en), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      chk("postrst_quiet", 64'({busy, mvu_wr_en}), 64'(0));
    end
    fill(3);
    run_batch(32'd3, 32'h600, -1, f, l, n);
    chk("postrst_nwr", 64'(n), 64'(3));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
